// File: rtl/num.sv
// NUM: folds ten 6-bit character bytes into a 30-bit binary magnitude, most significant digit first.
// Define NUM_OVERFLOW_EN to add the sticky overflow output; without it the result wraps mod 2^30.
module num (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [59:0] in,
  output logic        stop,
  output logic [29:0] out
`ifdef NUM_OVERFLOW_EN
  ,
  output logic        overflow
`endif
);

  logic [59:0] sh_q, sh_d;
  logic [29:0] acc_q, acc_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        run_q, run_d;
  logic        stop_q, stop_d;
  logic [5:0]  digit;

  // Reduces a character code to its decimal digit (0..9).
  function automatic logic [5:0] mod10(input logic [5:0] b);
    logic [5:0] r;
    r = b;
    if (r >= 6'd60)      r = r - 6'd60;
    else if (r >= 6'd50) r = r - 6'd50;
    else if (r >= 6'd40) r = r - 6'd40;
    else if (r >= 6'd30) r = r - 6'd30;
    else if (r >= 6'd20) r = r - 6'd20;
    else if (r >= 6'd10) r = r - 6'd10;
    return r;
  endfunction

`ifdef NUM_OVERFLOW_EN
  logic        ovf_q, ovf_d;
  logic [33:0] prod;
  logic [30:0] sum;

  always_comb begin
    prod = ({4'd0, acc_q} << 3) + ({4'd0, acc_q} << 1);
    sum  = {1'b0, prod[29:0]} + {25'd0, digit};
  end
`else
  logic [29:0] next_acc;

  always_comb begin
    next_acc = (acc_q << 3) + (acc_q << 1) + {24'd0, digit};
  end
`endif

  always_comb begin
    sh_d   = sh_q;
    acc_d  = acc_q;
    cnt_d  = cnt_q;
    run_d  = run_q;
    stop_d = 1'b0;
`ifdef NUM_OVERFLOW_EN
    ovf_d  = ovf_q;
`endif
    digit  = mod10(sh_q[59:54]);
    if (start) begin
      sh_d  = in;
      acc_d = 30'd0;
      cnt_d = 4'd0;
      run_d = 1'b1;
`ifdef NUM_OVERFLOW_EN
      ovf_d = 1'b0;
`endif
    end else if (run_q) begin
`ifdef NUM_OVERFLOW_EN
      acc_d = sum[29:0];
      ovf_d = ovf_q | (|prod[33:30]) | sum[30];
`else
      acc_d = next_acc;
`endif
      sh_d  = {sh_q[53:0], 6'd0};
      cnt_d = cnt_q + 4'd1;
      if (cnt_q == 4'd9) begin
        run_d  = 1'b0;
        stop_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sh_q   <= 60'd0;
      acc_q  <= 30'd0;
      cnt_q  <= 4'd0;
      run_q  <= 1'b0;
      stop_q <= 1'b0;
`ifdef NUM_OVERFLOW_EN
      ovf_q  <= 1'b0;
`endif
    end else begin
      sh_q   <= sh_d;
      acc_q  <= acc_d;
      cnt_q  <= cnt_d;
      run_q  <= run_d;
      stop_q <= stop_d;
`ifdef NUM_OVERFLOW_EN
      ovf_q  <= ovf_d;
`endif
    end
  end

  assign stop = stop_q;
  assign out  = acc_q;
`ifdef NUM_OVERFLOW_EN
  assign overflow = ovf_q;
`endif

endmodule

// File: tb/tb_num.sv
// Directed bench for num: character-to-binary conversion, latency, stop width, restart and reset.
module tb_num;
  logic        clk;
  logic        rst;
  logic        start;
  logic [59:0] in_v;
  logic        stop;
  logic [29:0] out;
  logic        ovf_w;

  int n_cmp = 0;
  int n_bad = 0;

  typedef int bytes_t[10];

`ifdef NUM_OVERFLOW_EN
  num dut (.clk(clk), .rst(rst), .start(start), .in(in_v), .stop(stop), .out(out), .overflow(ovf_w));
`else
  num dut (.clk(clk), .rst(rst), .start(start), .in(in_v), .stop(stop), .out(out));
  assign ovf_w = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [59:0] pk(input bytes_t b);
    logic [59:0] v;
    v = '0;
    for (int k = 0; k < 10; k++) v[59-6*k -: 6] = 6'(b[k]);
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one conversion; reports latency to the first stop, the result then, and whether stop fell after one cycle.
  task automatic do_conv(input logic [59:0] v, output int lat, output logic [29:0] o,
                         output logic ov, output logic narrow);
    in_v = v;
    start = 1'b1;
    tick();
    start = 1'b0;
    lat = -1;
    o = '0;
    ov = 1'b0;
    for (int i = 1; i <= 20 && lat < 0; i++) begin
      tick();
      if (stop) begin
        lat = i;
        o = out;
        ov = ovf_w;
      end
    end
    tick();
    narrow = (lat >= 0) && !stop;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    in_v = '0;
    tick();
    tick();
    n_cmp++;
    if (stop !== 1'b0 || out !== 30'd0 || ovf_w !== 1'b0) begin
      n_bad++;
      $display("FAIL reset: stop=%b out=%0d ovf=%b, need 0/0/0", stop, out, ovf_w);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_conv(input string name, input bytes_t b, input logic [29:0] exp_out,
                           input logic exp_ovf);
    int lat;
    logic [29:0] o;
    logic ov, narrow;
    do_conv(pk(b), lat, o, ov, narrow);
    n_cmp++;
    if (lat !== 10) begin
      n_bad++;
      $display("FAIL %s latency: got %0d cycles, need 10", name, lat);
    end
    n_cmp++;
    if (o !== exp_out) begin
      n_bad++;
      $display("FAIL %s out: got %0d, need %0d", name, o, exp_out);
    end
`ifdef NUM_OVERFLOW_EN
    n_cmp++;
    if (ov !== exp_ovf) begin
      n_bad++;
      $display("FAIL %s overflow: got %b, need %b", name, ov, exp_ovf);
    end
`else
    if (ov !== 1'b0 && exp_ovf === 1'bx) $display("unreachable");
`endif
    n_cmp++;
    if (narrow !== 1'b1) begin
      n_bad++;
      $display("FAIL %s stop width: stop still %b after one cycle, need 0", name, stop);
    end
    n_cmp++;
    if (out !== exp_out) begin
      n_bad++;
      $display("FAIL %s out hold: got %0d, need %0d", name, out, exp_out);
    end
  endtask

  task automatic test_partial();
    in_v = pk('{0, 0, 31, 32, 39, 37, 57, 47, 30, 30});
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    n_cmp++;
    if (out !== 30'd12) begin
      n_bad++;
      $display("FAIL partial acc after 4 digits: got %0d, need 12", out);
    end
    for (int i = 0; i < 10; i++) tick();
  endtask

  task automatic test_restart();
    int lat;
    logic seen;
    seen = 1'b0;
    in_v = pk('{39, 39, 39, 39, 39, 39, 39, 39, 39, 39});
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    in_v = pk('{0, 0, 31, 32, 39, 37, 57, 47, 30, 30});
    start = 1'b1;
    tick();
    start = 1'b0;
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (stop) begin
        if (lat < 0) lat = i;
        else seen = 1'b1;
      end
    end
    n_cmp++;
    if (lat !== 10) begin
      n_bad++;
      $display("FAIL restart latency: first stop %0d cycles after second start, need 10", lat);
    end
    n_cmp++;
    if (out !== 30'd12977700) begin
      n_bad++;
      $display("FAIL restart out: got %0d, need 12977700", out);
    end
    n_cmp++;
    if (seen !== 1'b0) begin
      n_bad++;
      $display("FAIL restart extra stop: got a second stop, need exactly one");
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    logic [29:0] o;
    logic ov, narrow;
    in_v = pk('{30, 30, 30, 30, 30, 30, 30, 30, 30, 39});
    start = 1'b1;
    tick();
    start = 1'b0;
    lat = -1;
    for (int i = 1; i <= 20 && lat < 0; i++) begin
      tick();
      if (stop) lat = i;
    end
    n_cmp++;
    if (lat !== 10 || out !== 30'd9) begin
      n_bad++;
      $display("FAIL b2b first: latency %0d out %0d, need 10 and 9", lat, out);
    end
    // start lands in the stop cycle
    do_conv(pk('{0, 1, 2, 3, 4, 5, 6, 7, 8, 9}), lat, o, ov, narrow);
    n_cmp++;
    if (lat !== 10 || o !== 30'd123456789 || narrow !== 1'b1) begin
      n_bad++;
      $display("FAIL b2b second: latency %0d out %0d narrow %b, need 10 123456789 1", lat, o, narrow);
    end
  endtask

  task automatic test_rst_mid();
    logic seen;
    seen = 1'b0;
    in_v = pk('{63, 63, 63, 63, 63, 63, 63, 63, 63, 63});
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    rst = 1'b1;
    start = 1'b1;
    tick();
    rst = 1'b0;
    start = 1'b0;
    n_cmp++;
    if (stop !== 1'b0 || out !== 30'd0 || ovf_w !== 1'b0) begin
      n_bad++;
      $display("FAIL rst mid: stop=%b out=%0d ovf=%b, need 0/0/0", stop, out, ovf_w);
    end
    for (int i = 0; i < 15; i++) begin
      tick();
      if (stop) seen = 1'b1;
    end
    n_cmp++;
    if (seen !== 1'b0 || out !== 30'd0) begin
      n_bad++;
      $display("FAIL rst mid later: stop seen=%b out=%0d, need 0 and 0", seen, out);
    end
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    in_v = '0;
    test_reset();
    test_conv("zeros", '{30, 30, 30, 30, 30, 30, 30, 30, 30, 30}, 30'd0, 1'b0);
    test_conv("knuth", '{0, 0, 31, 32, 39, 37, 57, 47, 30, 30}, 30'd12977700, 1'b0);
    test_conv("maxfit", '{31, 30, 37, 33, 37, 34, 31, 38, 32, 33}, 30'h3FFFFFFF, 1'b0);
    test_conv("maxplus1", '{31, 30, 37, 33, 37, 34, 31, 38, 32, 34}, 30'd0, 1'b1);
    test_conv("all39", '{39, 39, 39, 39, 39, 39, 39, 39, 39, 39}, 30'd336323583, 1'b1);
    test_conv("all63", '{63, 63, 63, 63, 63, 63, 63, 63, 63, 63}, 30'd112107861, 1'b1);
    test_conv("digits", '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9}, 30'd123456789, 1'b0);
    test_partial();
    test_restart();
    test_back_to_back();
    test_rst_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
